riscv_v_shifter_pipe: RTL

Pipelined, handshaked vector shift unit for the RISC-V V datapath. It generalises the combinational byte-sliced shifter in four ways:
- parametrised data width, maximum SEW and pipeline depth;
- per-element or scalar-broadcast shift amounts;
- a rotate mode;
- per-element masking.

It sits in the vector ALU execute slot between operand read and writeback, and accepts one operation per cycle under valid/ready flow control.

---
 rtl/riscv_v_shifter_pipe.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/riscv_v_shifter_pipe.sv
// Pipelined vector shifter: SLL/SRL/SRA/ROR per element with masking and valid/ready flow control.
// The log2(MAX_SEW) binary shift levels are spread over PIPE_STAGES register stages.
module riscv_v_shifter_pipe #(
    parameter int DATA_WIDTH  = 128,
    parameter int MAX_SEW     = 64,
    parameter int PIPE_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_op,
    input  logic [1:0]              in_sew,
    input  logic                    in_scalar,
    input  logic [MAX_SEW-1:0]      in_rs1,
    input  logic [DATA_WIDTH-1:0]   in_srca,
    input  logic [DATA_WIDTH-1:0]   in_srcb,
    input  logic [DATA_WIDTH/8-1:0] in_mask,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_result,
    output logic                    out_err
);
    localparam int NUM_LEVELS = $clog2(MAX_SEW);
    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;

    // Per-element shift amount, already reduced to log2(SEW) bits and placed in the
    // element's low bits. Inactive elements get amount 0, which leaves srcb untouched.
    function automatic logic [DATA_WIDTH-1:0] prep_amt(
        input logic [1:0]              sew,
        input logic                    scalar,
        input logic [MAX_SEW-1:0]      rs1,
        input logic [DATA_WIDTH-1:0]   srca,
        input logic [DATA_WIDTH/8-1:0] mask
    );
        logic [DATA_WIDTH-1:0] amt;
        int w;
        amt = '0;
        w = 8 << sew;
        if (w <= MAX_SEW) begin
            for (int e = 0; e < DATA_WIDTH / 8; e++) begin
                if (e < DATA_WIDTH / w) begin
                    if (mask[e * w / 8]) begin
                        for (int b = 0; b < NUM_LEVELS; b++) begin
                            if ((1 << b) < w) begin
                                amt[e * w + b] = scalar ? rs1[b] : srca[e * w + b];
                            end
                        end
                    end
                end
            end
        end
        return amt;
    endfunction

    // One binary level: each element whose amount bit lvl is set moves by 2**lvl.
    function automatic logic [DATA_WIDTH-1:0] shift_level(
        input logic [DATA_WIDTH-1:0] data,
        input logic [DATA_WIDTH-1:0] amt,
        input logic [1:0]            op,
        input logic [1:0]            sew,
        input int                    lvl
    );
        logic [DATA_WIDTH-1:0] res;
        logic [63:0] x;
        logic [63:0] r;
        logic [63:0] wmask;
        int w;
        int sh;
        res = data;
        w = 8 << sew;
        sh = 1 << lvl;
        x = '0;
        r = '0;
        wmask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (w <= MAX_SEW && sh < w) begin
            for (int e = 0; e < DATA_WIDTH / 8; e++) begin
                if (e < DATA_WIDTH / w) begin
                    if (amt[e * w + lvl]) begin
                        x = '0;
                        for (int b = 0; b < 64; b++) begin
                            if (b < w) x[b] = data[e * w + b];
                        end
                        case (op)
                            OP_SLL:  r = (x << sh) & wmask;
                            OP_SRL:  r = x >> sh;
                            OP_SRA:  r = (x >> sh) | (x[w - 1] ? (wmask & ~(wmask >> sh)) : 64'd0);
                            default: r = ((x >> sh) | (x << (w - sh))) & wmask;
                        endcase
                        for (int b = 0; b < 64; b++) begin
                            if (b < w) res[e * w + b] = r[b];
                        end
                    end
                end
            end
        end
        return res;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] run_levels(
        input logic [DATA_WIDTH-1:0] data,
        input logic [DATA_WIDTH-1:0] amt,
        input logic [1:0]            op,
        input logic [1:0]            sew,
        input int                    lo,
        input int                    hi
    );
        logic [DATA_WIDTH-1:0] d;
        d = data;
        for (int l = 0; l < NUM_LEVELS; l++) begin
            if (l >= lo && l < hi) d = shift_level(d, amt, op, sew, l);
        end
        return d;
    endfunction

    logic                   valid_reg [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  data_reg  [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  amt_reg   [PIPE_STAGES];
    logic [1:0]             op_reg    [PIPE_STAGES];
    logic [1:0]             sew_reg   [PIPE_STAGES];
    logic                   err_reg   [PIPE_STAGES];

    logic                   src_valid [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  src_data  [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  src_amt   [PIPE_STAGES];
    logic [1:0]             src_op    [PIPE_STAGES];
    logic [1:0]             src_sew   [PIPE_STAGES];
    logic                   src_err   [PIPE_STAGES];
    logic [DATA_WIDTH-1:0]  data_next [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] advance;

    logic                   entry_err;
    logic [DATA_WIDTH-1:0]  entry_data;
    logic [DATA_WIDTH-1:0]  entry_amt;
    logic                   unused_bits;

    // Illegal SEW is turned into a zero vector with zero shift so it flows as a normal slot.
    assign entry_err   = (8 << in_sew) > MAX_SEW;
    assign entry_data  = entry_err ? '0 : in_srcb;
    assign entry_amt   = prep_amt(in_sew, in_scalar, in_rs1, in_srca, in_mask);
    assign unused_bits = ^{in_rs1, in_srca, in_mask};

    generate
        for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            localparam int LVL_LO = gi * NUM_LEVELS / PIPE_STAGES;
            localparam int LVL_HI = (gi + 1) * NUM_LEVELS / PIPE_STAGES;

            if (gi == PIPE_STAGES - 1) begin : g_last
                assign advance[gi] = out_ready || !valid_reg[gi];
            end else begin : g_mid
                assign advance[gi] = !valid_reg[gi] || advance[gi + 1];
            end

            if (gi == 0) begin : g_first
                assign src_valid[gi] = in_valid;
                assign src_data[gi]  = entry_data;
                assign src_amt[gi]   = entry_amt;
                assign src_op[gi]    = in_op;
                assign src_sew[gi]   = in_sew;
                assign src_err[gi]   = entry_err;
            end else begin : g_chain
                assign src_valid[gi] = valid_reg[gi - 1];
                assign src_data[gi]  = data_reg[gi - 1];
                assign src_amt[gi]   = amt_reg[gi - 1];
                assign src_op[gi]    = op_reg[gi - 1];
                assign src_sew[gi]   = sew_reg[gi - 1];
                assign src_err[gi]   = err_reg[gi - 1];
            end

            assign data_next[gi] = run_levels(src_data[gi], src_amt[gi], src_op[gi],
                                              src_sew[gi], LVL_LO, LVL_HI);
        end
    endgenerate

    // Flush outranks every advance; payload registers only load when a valid op moves in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                valid_reg[k] <= 1'b0;
                data_reg[k]  <= '0;
                amt_reg[k]   <= '0;
                op_reg[k]    <= '0;
                sew_reg[k]   <= '0;
                err_reg[k]   <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                valid_reg[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (advance[k]) begin
                    valid_reg[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        data_reg[k] <= data_next[k];
                        amt_reg[k]  <= src_amt[k];
                        op_reg[k]   <= src_op[k];
                        sew_reg[k]  <= src_sew[k];
                        err_reg[k]  <= src_err[k];
                    end
                end
            end
        end
    end

    assign in_ready   = advance[0] && !flush;
    assign out_valid  = valid_reg[PIPE_STAGES-1];
    assign out_result = data_reg[PIPE_STAGES-1];
    assign out_err    = err_reg[PIPE_STAGES-1];
endmodule
